// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Holds the fetch FSM encoding, the default reset PC and a PC increment helper.
package fetch_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h00100000;

    // Natural 32-bit truncation gives the required wrap from 0xFFFFFFFC to 0.
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_hold_reg.sv
// Enable-load register that parks a fetched instruction while the pipeline stalls.
// Latency: one cycle from en to q; no backpressure, loads whenever en is high.
module fetch_hold_reg #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: one outstanding imem request, bypass of zero-wait data, stall hold.
// Latency: InstrF is combinational from ImemRdata on ack; StallF parks the word in HOLD.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        StallF,
    input  logic        PCSrcD,
    input  logic [31:0] PCBranchD,
    output logic        ImemReq,
    output logic [31:0] ImemAddr,
    input  logic        ImemAck,
    input  logic [31:0] ImemRdata,
    output logic [31:0] InstrF,
    output logic [31:0] PCPlus4F,
    output logic        FetchBusy
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pcf_q, pcf_d;
    logic [31:0]  redir_q, redir_d;
    logic         kill_q, kill_d;
    logic         hold_en;
    logic [31:0]  hold_q;
    logic         redir_ok;

    assign redir_ok = PCSrcD & ~StallF;

    // The outstanding request keeps PCF until acked, so the address is always PCF.
    assign ImemAddr = pcf_q;
    assign PCPlus4F = pc_plus4(pcf_q);

    fetch_hold_reg #(
        .W (32)
    ) u_hold (
        .clk (clk),
        .rst (reset),
        .en  (hold_en),
        .d   (ImemRdata),
        .q   (hold_q)
    );

    always_comb begin
        state_d   = state_q;
        pcf_d     = pcf_q;
        redir_d   = redir_q;
        kill_d    = kill_q;
        hold_en   = 1'b0;
        ImemReq   = 1'b0;
        InstrF    = 32'd0;
        FetchBusy = 1'b1;

        case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
            end

            S_REQ: begin
                ImemReq = 1'b1;
                if (kill_q) begin
                    // Wrong-path response: discard it and restart at the latest target.
                    if (ImemAck) begin
                        kill_d = 1'b0;
                        pcf_d  = redir_ok ? PCBranchD : redir_q;
                    end else if (redir_ok) begin
                        redir_d = PCBranchD;
                    end
                end else if (ImemAck) begin
                    if (redir_ok) begin
                        pcf_d = PCBranchD;
                    end else begin
                        InstrF    = ImemRdata;
                        FetchBusy = 1'b0;
                        if (StallF) begin
                            hold_en = 1'b1;
                            state_d = S_HOLD;
                        end else begin
                            pcf_d = pc_plus4(pcf_q);
                        end
                    end
                end else if (redir_ok) begin
                    kill_d  = 1'b1;
                    redir_d = PCBranchD;
                end
            end

            S_HOLD: begin
                if (redir_ok) begin
                    pcf_d   = PCBranchD;
                    state_d = S_REQ;
                end else begin
                    InstrF    = hold_q;
                    FetchBusy = 1'b0;
                    if (!StallF) begin
                        pcf_d   = pc_plus4(pcf_q);
                        state_d = S_REQ;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            pcf_q   <= RESET_PC;
            redir_q <= 32'd0;
            kill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pcf_q   <= pcf_d;
            redir_q <= redir_d;
            kill_q  <= kill_d;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: zero-wait streaming, latency, stall hold, kill, wrap, reset.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        StallF;
    logic        PCSrcD;
    logic [31:0] PCBranchD;
    logic        ImemReq;
    logic [31:0] ImemAddr;
    logic        ImemAck;
    logic [31:0] ImemRdata;
    logic [31:0] InstrF;
    logic [31:0] PCPlus4F;
    logic        FetchBusy;

    // zw=1: memory acks every request in the same cycle with data = addr ^ 0xDEAD0000.
    logic        zw;
    logic        ack_drv;
    logic [31:0] rdata_drv;

    int passed = 0;
    int total  = 0;

    assign ImemAck   = zw ? ImemReq : ack_drv;
    assign ImemRdata = zw ? (ImemAddr ^ 32'hDEAD0000) : rdata_drv;

    always #5 clk = ~clk;

    fetch_stage #(
        .RESET_PC (32'h00100000)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .StallF    (StallF),
        .PCSrcD    (PCSrcD),
        .PCBranchD (PCBranchD),
        .ImemReq   (ImemReq),
        .ImemAddr  (ImemAddr),
        .ImemAck   (ImemAck),
        .ImemRdata (ImemRdata),
        .InstrF    (InstrF),
        .PCPlus4F  (PCPlus4F),
        .FetchBusy (FetchBusy)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; StallF = 1'b0; PCSrcD = 1'b0; PCBranchD = 32'd0;
        zw = 1'b0; ack_drv = 1'b0; rdata_drv = 32'd0;
        cyc(); cyc();
        #1;
        total++; if (ImemReq !== 1'b0) $display("FAIL reset_req got %0b want 0", ImemReq); else passed++;
        total++; if (InstrF !== 32'd0) $display("FAIL reset_instr got %h want 0", InstrF); else passed++;
        total++; if (PCPlus4F !== 32'h00100004) $display("FAIL reset_pcp4 got %h want 00100004", PCPlus4F); else passed++;
        total++; if (FetchBusy !== 1'b1) $display("FAIL reset_busy got %0b want 1", FetchBusy); else passed++;
    endtask

    task automatic test_zero_wait();
        cyc();
        reset = 1'b0;
        #1;
        total++; if (ImemReq !== 1'b0) $display("FAIL idle_req got %0b want 0", ImemReq); else passed++;
        cyc();
        zw = 1'b1;
        #1;
        total++; if (ImemAddr !== 32'h00100000) $display("FAIL zw_addr0 got %h want 00100000", ImemAddr); else passed++;
        total++; if (InstrF !== 32'hDEBD0000) $display("FAIL zw_instr0 got %h want DEBD0000", InstrF); else passed++;
        total++; if (FetchBusy !== 1'b0) $display("FAIL zw_busy0 got %0b want 0", FetchBusy); else passed++;
        cyc(); #1;
        total++; if (ImemAddr !== 32'h00100004) $display("FAIL zw_addr1 got %h want 00100004", ImemAddr); else passed++;
        total++; if (InstrF !== 32'hDEBD0004) $display("FAIL zw_instr1 got %h want DEBD0004", InstrF); else passed++;
        cyc(); #1;
        total++; if (ImemAddr !== 32'h00100008) $display("FAIL zw_addr2 got %h want 00100008", ImemAddr); else passed++;
        total++; if (InstrF !== 32'hDEBD0008) $display("FAIL zw_instr2 got %h want DEBD0008", InstrF); else passed++;
        zw = 1'b0; ack_drv = 1'b0;
        cyc();
    endtask

    task automatic test_latency();
        for (int i = 0; i < 3; i++) begin
            ack_drv = 1'b0;
            #1;
            total++; if (InstrF !== 32'd0 || FetchBusy !== 1'b1)
                $display("FAIL lat_wait%0d got instr %h busy %0b want 0/1", i, InstrF, FetchBusy); else passed++;
            total++; if (ImemAddr !== 32'h00100008) $display("FAIL lat_addr%0d got %h want 00100008", i, ImemAddr); else passed++;
            cyc();
        end
        ack_drv = 1'b1; rdata_drv = 32'h11112222;
        #1;
        total++; if (InstrF !== 32'h11112222) $display("FAIL lat_instr got %h want 11112222", InstrF); else passed++;
        total++; if (FetchBusy !== 1'b0) $display("FAIL lat_busy got %0b want 0", FetchBusy); else passed++;
        cyc();
        ack_drv = 1'b0;
        #1;
        total++; if (ImemAddr !== 32'h0010000C) $display("FAIL lat_next got %h want 0010000C", ImemAddr); else passed++;
        total++; if (InstrF !== 32'd0) $display("FAIL lat_bubble got %h want 0", InstrF); else passed++;
    endtask

    task automatic test_stall_hold();
        ack_drv = 1'b1; rdata_drv = 32'hCAFEF00D; StallF = 1'b1;
        #1;
        total++; if (InstrF !== 32'hCAFEF00D) $display("FAIL hold_c0 got %h want CAFEF00D", InstrF); else passed++;
        cyc();
        ack_drv = 1'b0; rdata_drv = 32'h0;
        #1;
        total++; if (ImemReq !== 1'b0) $display("FAIL hold_req got %0b want 0", ImemReq); else passed++;
        total++; if (InstrF !== 32'hCAFEF00D) $display("FAIL hold_c1 got %h want CAFEF00D", InstrF); else passed++;
        total++; if (PCPlus4F !== 32'h00100010) $display("FAIL hold_pc got %h want 00100010", PCPlus4F); else passed++;
        cyc();
        StallF = 1'b0;
        #1;
        total++; if (InstrF !== 32'hCAFEF00D) $display("FAIL hold_c2 got %h want CAFEF00D", InstrF); else passed++;
        total++; if (ImemReq !== 1'b0) $display("FAIL hold_req2 got %0b want 0", ImemReq); else passed++;
        cyc();
        #1;
        total++; if (ImemReq !== 1'b1 || ImemAddr !== 32'h00100010)
            $display("FAIL hold_release got req %0b addr %h want 1/00100010", ImemReq, ImemAddr); else passed++;
    endtask

    task automatic test_redirect_kill();
        PCSrcD = 1'b1; PCBranchD = 32'h00100400;
        #1;
        total++; if (ImemAddr !== 32'h00100010) $display("FAIL kill_addr0 got %h want 00100010", ImemAddr); else passed++;
        cyc();
        PCSrcD = 1'b0; PCBranchD = 32'h0;
        #1;
        total++; if (ImemAddr !== 32'h00100010 || ImemReq !== 1'b1)
            $display("FAIL kill_addr1 got req %0b addr %h want 1/00100010", ImemReq, ImemAddr); else passed++;
        total++; if (InstrF !== 32'd0 || FetchBusy !== 1'b1)
            $display("FAIL kill_wait got instr %h busy %0b want 0/1", InstrF, FetchBusy); else passed++;
        cyc();
        ack_drv = 1'b1; rdata_drv = 32'hBAD0BAD0;
        #1;
        total++; if (InstrF !== 32'd0) $display("FAIL kill_drop got %h want 0", InstrF); else passed++;
        cyc();
        ack_drv = 1'b0;
        #1;
        total++; if (ImemAddr !== 32'h00100400 || ImemReq !== 1'b1)
            $display("FAIL kill_target got req %0b addr %h want 1/00100400", ImemReq, ImemAddr); else passed++;
        // Redirect coinciding with an ack replaces PCF directly.
        ack_drv = 1'b1; PCSrcD = 1'b1; PCBranchD = 32'h00100800;
        cyc();
        ack_drv = 1'b0; PCSrcD = 1'b0;
        #1;
        total++; if (ImemAddr !== 32'h00100800) $display("FAIL redir_ack got %h want 00100800", ImemAddr); else passed++;
    endtask

    task automatic test_ignore_and_wrap();
        PCSrcD = 1'b1; StallF = 1'b1; PCBranchD = 32'h12345678;
        cyc();
        PCSrcD = 1'b0; StallF = 1'b0;
        #1;
        total++; if (ImemAddr !== 32'h00100800) $display("FAIL ignore_redir got %h want 00100800", ImemAddr); else passed++;
        ack_drv = 1'b1; PCSrcD = 1'b1; PCBranchD = 32'hFFFFFFFC;
        cyc();
        ack_drv = 1'b0; PCSrcD = 1'b0;
        #1;
        total++; if (ImemAddr !== 32'hFFFFFFFC) $display("FAIL wrap_pc got %h want FFFFFFFC", ImemAddr); else passed++;
        total++; if (PCPlus4F !== 32'h00000000) $display("FAIL wrap_pcp4 got %h want 00000000", PCPlus4F); else passed++;
        ack_drv = 1'b1; rdata_drv = 32'h00000013;
        #1;
        total++; if (InstrF !== 32'h00000013) $display("FAIL wrap_instr got %h want 00000013", InstrF); else passed++;
        cyc();
        ack_drv = 1'b0;
        #1;
        total++; if (ImemAddr !== 32'h00000000) $display("FAIL wrap_next got %h want 00000000", ImemAddr); else passed++;
    endtask

    task automatic test_reset_mid_req();
        reset = 1'b1;
        #1;
        total++; if (ImemReq !== 1'b0) $display("FAIL rst_mid_req got %0b want 0", ImemReq); else passed++;
        total++; if (PCPlus4F !== 32'h00100004) $display("FAIL rst_mid_pc got %h want 00100004", PCPlus4F); else passed++;
        cyc();
        reset = 1'b0;
        #1;
        total++; if (ImemReq !== 1'b0) $display("FAIL rst_idle got %0b want 0", ImemReq); else passed++;
        cyc();
        #1;
        total++; if (ImemReq !== 1'b1 || ImemAddr !== 32'h00100000)
            $display("FAIL rst_restart got req %0b addr %h want 1/00100000", ImemReq, ImemAddr); else passed++;
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_latency();
        test_stall_hold();
        test_redirect_kill();
        test_ignore_and_wrap();
        test_reset_mid_req();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
